gf180mcu_fd_sc_mcu7t5v0__dlycal_16: RTL

GF180MCU_FD_SC_MCU7T5V0__DLYCAL_16 -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__dlycal_16

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__dlycal_16.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlycal_16.sv
// Delay-chain calibrator: launches an edge into a delay chain, samples the
// tap outputs one clock later, and averages the tap count over 2^NAVG_LOG2
// runs. A chain that never settles to all-zero while armed aborts the run
// with CODE all ones and ERR set.
// Optional macro GF180MCU_FD_SC_DLYCAL_BUBBLE_EN: flags non-thermometer
// samples into ERR (CODE stays popcount based).
module gf180mcu_fd_sc_mcu7t5v0__dlycal_16 #(
  parameter int NTAP      = 16,
  parameter int NAVG_LOG2 = 2,
  parameter int ARM_TMO   = 15
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  output logic                       LAUNCH,
  input  logic [NTAP-1:0]            TAP,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [$clog2(NTAP+1)-1:0]  CODE,
  output logic                       ERR
);

  localparam int CW  = $clog2(NTAP + 1);
  localparam int AW  = CW + NAVG_LOG2;
  localparam int ITW = (NAVG_LOG2 > 0) ? NAVG_LOG2 : 1;
  localparam logic [ITW-1:0] LAST_ITER = ITW'((1 << NAVG_LOG2) - 1);
  localparam logic [7:0]     TMO_LAST  = 8'(ARM_TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FIRE,
    S_CAPT,
    S_FIN
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             timeout;
  logic [ITW-1:0]   iter_cnt;
  logic [7:0]       arm_cnt;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_nx;
  logic [NTAP-1:0]  tap_p1;
  logic [CW-1:0]    pop_now;
  logic             bub_flag;
  logic             bub_now;
  logic             tap_nz;

  function automatic logic [CW-1:0] popcount(input logic [NTAP-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < NTAP; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

`ifdef GF180MCU_FD_SC_DLYCAL_BUBBLE_EN
  // A thermometer code 0..01..1 plus one has no bit in common with itself.
  function automatic logic is_bubble(input logic [NTAP-1:0] v);
    logic [NTAP:0] s;
    s = {1'b0, v};
    return |(s & (s + 1'b1));
  endfunction

  assign bub_now = is_bubble(tap_p1);
`else
  assign bub_now = 1'b0;
`endif

  assign tap_nz  = |TAP;
  assign pop_now = popcount(tap_p1);
  assign acc_nx  = acc + AW'(pop_now);

  // Next-state decode; timeout marks the ARM abort path.
  always_comb begin
    state_nx = state;
    timeout  = 1'b0;
    case (state)
      S_IDLE: if (START) state_nx = S_ARM;
      S_ARM: begin
        if (!tap_nz) begin
          state_nx = S_FIRE;
        end else if (arm_cnt == TMO_LAST) begin
          timeout  = 1'b1;
          state_nx = S_FIN;
        end
      end
      S_FIRE: state_nx = S_CAPT;
      S_CAPT: state_nx = (iter_cnt == LAST_ITER) ? S_FIN : S_ARM;
      S_FIN:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Stage p1: chain sample taken on the edge that ends FIRE.
  always_ff @(posedge CLK) begin
    if (state == S_FIRE) tap_p1 <= TAP;
  end

  // State register, registered outputs, counters and result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      LAUNCH   <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      CODE     <= '0;
      ERR      <= 1'b0;
      iter_cnt <= '0;
      arm_cnt  <= '0;
      acc      <= '0;
      bub_flag <= 1'b0;
    end else begin
      state  <= state_nx;
      LAUNCH <= (state_nx == S_FIRE);
      BUSY   <= (state_nx != S_IDLE);
      DONE   <= (state_nx == S_FIN);
      case (state)
        S_IDLE: begin
          if (START) begin
            iter_cnt <= '0;
            arm_cnt  <= '0;
            acc      <= '0;
            bub_flag <= 1'b0;
          end
        end
        S_ARM: begin
          arm_cnt <= tap_nz ? arm_cnt + 8'd1 : 8'd0;
          if (timeout) begin
            CODE <= '1;
            ERR  <= 1'b1;
          end
        end
        S_FIRE: arm_cnt <= '0;
        // Stage p2: accumulate the sample and close the run on the last one.
        S_CAPT: begin
          acc      <= acc_nx;
          iter_cnt <= iter_cnt + 1'b1;
          bub_flag <= bub_flag | bub_now;
          if (iter_cnt == LAST_ITER) begin
            CODE <= acc_nx[AW-1:NAVG_LOG2];
            ERR  <= bub_flag | bub_now;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
